// File: rtl/ex_mem_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_skid_reg
// Purpose  : EX/MEM pipeline register with a one-entry skid buffer. MAIN
//            drives the MEM stage; SKID catches the one entry that was
//            already accepted when MEM stalls. ex_ready is a pure function
//            of the held state, so no combinational path links me_ready
//            to ex_ready.
// Ports    : clk, rst (sync, active-low), flush (sync kill of held entries)
//            ex_valid/ex_ready + ex_* fields  : upstream handshake/payload
//            me_valid/me_ready + me_* fields  : downstream handshake/payload
//            occupancy                        : entries held (0..2)
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_skid_reg #(
    parameter int XLEN   = 32,
    parameter int MAT_W  = 128,
    parameter int CTRL_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [XLEN-1:0]   ex_regs_data2,
    input  logic [XLEN-1:0]   ex_alu_o,
    input  logic [MAT_W-1:0]  ex_matrix_o,
    input  logic [4:0]        ex_rd,
    input  logic [4:0]        ex_rs2,
    input  logic [CTRL_W-1:0] ex_ctrl,
    output logic              me_valid,
    input  logic              me_ready,
    output logic [XLEN-1:0]   me_regs_data2,
    output logic [XLEN-1:0]   me_alu_o,
    output logic [MAT_W-1:0]  me_matrix_o,
    output logic [4:0]        me_rd,
    output logic [4:0]        me_rs2,
    output logic [CTRL_W-1:0] me_ctrl,
    output logic [1:0]        occupancy
);

    // Entry packing: ctrl sits in the low bits so it can be cleared by slice.
    localparam int ENT_W = XLEN + XLEN + MAT_W + 5 + 5 + CTRL_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ENT_W-1:0]   main_q,  main_d;
    logic [ENT_W-1:0]   skid_q,  skid_d;
    logic               main_vld_q, main_vld_d;
    logic               skid_vld_q, skid_vld_d;

    logic [ENT_W-1:0]   w_ex_entry;
    logic [CTRL_W-1:0]  w_main_ctrl;
    logic               w_accept;
    logic               w_consume;

    assign w_ex_entry = {ex_regs_data2, ex_alu_o, ex_matrix_o, ex_rd, ex_rs2, ex_ctrl};

    // Handshakes. Both outputs are gated by rst so nothing is offered or
    // taken while reset is held, even before the first reset edge.
    assign ex_ready  = rst && (state_q != ST_FULL);
    assign me_valid  = rst && main_vld_q;
    assign w_accept  = ex_valid && ex_ready;
    assign w_consume = me_valid && me_ready;

    assign {me_regs_data2, me_alu_o, me_matrix_o, me_rd, me_rs2, w_main_ctrl} = main_q;

    // A bubble must never carry memory or write-back control, while the
    // data fields keep their last value to avoid needless toggling.
    assign me_ctrl   = me_valid ? w_main_ctrl : '0;
    assign occupancy = {1'b0, main_vld_q} + {1'b0, skid_vld_q};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;

        if (flush) begin
            // Kill wins over any simultaneous accept/consume; the offered
            // entry is dropped. Control is zeroed so stale ctrl can never
            // resurface, data is left as is.
            state_d                = ST_EMPTY;
            main_vld_d             = 1'b0;
            skid_vld_d             = 1'b0;
            main_d[CTRL_W-1:0]     = '0;
            skid_d[CTRL_W-1:0]     = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_accept) begin
                        main_d     = w_ex_entry;
                        main_vld_d = 1'b1;
                        state_d    = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_consume) begin
                        main_d = w_ex_entry;
                    end else if (w_accept) begin
                        // MEM stalled: park the new entry behind MAIN.
                        skid_d     = w_ex_entry;
                        skid_vld_d = 1'b1;
                        state_d    = ST_FULL;
                    end else if (w_consume) begin
                        main_vld_d = 1'b0;
                        state_d    = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // ex_ready is low here, so only a consume can happen.
                    if (w_consume) begin
                        main_d     = skid_q;
                        skid_d     = '0;
                        skid_vld_d = 1'b0;
                        state_d    = ST_ONE;
                    end
                end
                default: begin
                    state_d    = ST_EMPTY;
                    main_vld_d = 1'b0;
                    skid_vld_d = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_skid_reg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ex_mem_skid_reg
// Purpose  : Self-checking bench for ex_mem_skid_reg: directed vector table
//            (reset, streaming, backpressure, flush, bubble, reset in FULL)
//            followed by a randomized run against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_skid_reg;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          ex_valid;
    logic          ex_ready;
    logic [31:0]   ex_regs_data2;
    logic [31:0]   ex_alu_o;
    logic [127:0]  ex_matrix_o;
    logic [4:0]    ex_rd;
    logic [4:0]    ex_rs2;
    logic [8:0]    ex_ctrl;
    logic          me_valid;
    logic          me_ready;
    logic [31:0]   me_regs_data2;
    logic [31:0]   me_alu_o;
    logic [127:0]  me_matrix_o;
    logic [4:0]    me_rd;
    logic [4:0]    me_rs2;
    logic [8:0]    me_ctrl;
    logic [1:0]    occupancy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_mem_skid_reg #(.XLEN(32), .MAT_W(128), .CTRL_W(9)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_regs_data2 (ex_regs_data2),
        .ex_alu_o      (ex_alu_o),
        .ex_matrix_o   (ex_matrix_o),
        .ex_rd         (ex_rd),
        .ex_rs2        (ex_rs2),
        .ex_ctrl       (ex_ctrl),
        .me_valid      (me_valid),
        .me_ready      (me_ready),
        .me_regs_data2 (me_regs_data2),
        .me_alu_o      (me_alu_o),
        .me_matrix_o   (me_matrix_o),
        .me_rd         (me_rd),
        .me_rs2        (me_rs2),
        .me_ctrl       (me_ctrl),
        .occupancy     (occupancy)
    );

    typedef struct {
        logic        rst;
        logic        flush;
        logic        v;
        logic        mr;
        logic [31:0] alu;
        logic [8:0]  ctrl;
        logic [31:0] d2;
        logic        e_mv;
        logic [31:0] e_alu;
        logic [8:0]  e_ctrl;
        logic [31:0] e_d2;
        logic        e_rdy;
        logic [1:0]  e_occ;
    } vec_t;

    typedef struct {
        logic [31:0]  alu;
        logic [31:0]  d2;
        logic [127:0] mat;
        logic [4:0]   rd;
        logic [4:0]   rs2;
        logic [8:0]   ctrl;
    } ent_t;

    vec_t vecs[$];
    ent_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs: rst flush ex_valid me_ready alu ctrl d2 ; expected after edge:
    // me_valid me_alu_o me_ctrl me_regs_data2 ex_ready occupancy
    task automatic add(input logic r, input logic f, input logic v, input logic mr,
                       input logic [31:0] alu, input logic [8:0] ctrl, input logic [31:0] d2,
                       input logic emv, input logic [31:0] ealu, input logic [8:0] ectrl,
                       input logic [31:0] ed2, input logic erdy, input logic [1:0] eocc);
        vec_t t;
        t.rst = r; t.flush = f; t.v = v; t.mr = mr;
        t.alu = alu; t.ctrl = ctrl; t.d2 = d2;
        t.e_mv = emv; t.e_alu = ealu; t.e_ctrl = ectrl; t.e_d2 = ed2;
        t.e_rdy = erdy; t.e_occ = eocc;
        vecs.push_back(t);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc, con;
        ent_t e;

        rst = 1'b0; flush = 1'b0; ex_valid = 1'b0; me_ready = 1'b0;
        ex_regs_data2 = '0; ex_alu_o = '0; ex_matrix_o = '0;
        ex_rd = 5'd3; ex_rs2 = 5'd4; ex_ctrl = '0;

        // Reset held two cycles with an entry offered.
        add(0,0,1,0, 32'hDEADBEEF, 9'h1FF, 32'h5555,  0, 32'h0, 9'h0, 32'h0, 0, 2'd0);
        add(0,0,1,0, 32'hDEADBEEF, 9'h1FF, 32'h5555,  0, 32'h0, 9'h0, 32'h0, 0, 2'd0);
        // Streaming 1..8 with me_ready high: 1-cycle lag, occupancy 1.
        for (int i = 1; i <= 8; i++)
            add(1,0,1,1, i, 9'h001, 32'h100 + i,  1, i, 9'h001, 32'h100 + i, 1, 2'd1);
        // Drain to EMPTY: data held, ctrl forced zero.
        add(1,0,0,1, 32'h0, 9'h0, 32'h0,  0, 32'h8, 9'h0, 32'h108, 1, 2'd0);
        // Backpressure: A, B fill; C refused; then drain in order.
        add(1,0,1,0, 32'h11, 9'h002, 32'hA1,  1, 32'h11, 9'h002, 32'hA1, 1, 2'd1);
        add(1,0,1,0, 32'h22, 9'h002, 32'hA2,  1, 32'h11, 9'h002, 32'hA1, 0, 2'd2);
        add(1,0,1,0, 32'h33, 9'h002, 32'hA3,  1, 32'h11, 9'h002, 32'hA1, 0, 2'd2);
        add(1,0,1,1, 32'h33, 9'h002, 32'hA3,  1, 32'h22, 9'h002, 32'hA2, 1, 2'd1);
        add(1,0,1,1, 32'h33, 9'h002, 32'hA3,  1, 32'h33, 9'h002, 32'hA3, 1, 2'd1);
        add(1,0,0,1, 32'h0,  9'h000, 32'h0,   0, 32'h33, 9'h000, 32'hA3, 1, 2'd0);
        // Flush in FULL with accept+consume attempted the same cycle.
        add(1,0,1,0, 32'h44, 9'h003, 32'hB4,  1, 32'h44, 9'h003, 32'hB4, 1, 2'd1);
        add(1,0,1,0, 32'h55, 9'h003, 32'hB5,  1, 32'h44, 9'h003, 32'hB4, 0, 2'd2);
        add(1,1,1,1, 32'h66, 9'h003, 32'hB6,  0, 32'h44, 9'h000, 32'hB4, 1, 2'd0);
        // Flush while EMPTY is harmless.
        add(1,1,1,1, 32'h77, 9'h003, 32'hB7,  0, 32'h44, 9'h000, 32'hB4, 1, 2'd0);
        // Bubble after a single store.
        add(1,0,1,1, 32'h88, 9'h004, 32'hCAFE, 1, 32'h88, 9'h004, 32'hCAFE, 1, 2'd1);
        add(1,0,0,1, 32'h0,  9'h000, 32'h0,    0, 32'h88, 9'h000, 32'hCAFE, 1, 2'd0);
        // Reset while FULL discards both entries; next accept lands in MAIN.
        add(1,0,1,0, 32'h91, 9'h001, 32'h91,  1, 32'h91, 9'h001, 32'h91, 1, 2'd1);
        add(1,0,1,0, 32'h92, 9'h001, 32'h92,  1, 32'h91, 9'h001, 32'h91, 0, 2'd2);
        add(0,1,1,1, 32'h93, 9'h001, 32'h93,  0, 32'h0,  9'h000, 32'h0,  0, 2'd0);
        add(1,0,1,0, 32'h94, 9'h001, 32'h94,  1, 32'h94, 9'h001, 32'h94, 1, 2'd1);

        foreach (vecs[k]) begin
            rst = vecs[k].rst; flush = vecs[k].flush;
            ex_valid = vecs[k].v; me_ready = vecs[k].mr;
            ex_alu_o = vecs[k].alu; ex_ctrl = vecs[k].ctrl; ex_regs_data2 = vecs[k].d2;
            @(posedge clk); #1;
            chk($sformatf("v%0d me_valid", k),  64'(me_valid),      64'(vecs[k].e_mv));
            chk($sformatf("v%0d me_alu_o", k),  64'(me_alu_o),      64'(vecs[k].e_alu));
            chk($sformatf("v%0d me_ctrl", k),   64'(me_ctrl),       64'(vecs[k].e_ctrl));
            chk($sformatf("v%0d me_data2", k),  64'(me_regs_data2), 64'(vecs[k].e_d2));
            chk($sformatf("v%0d ex_ready", k),  64'(ex_ready),      64'(vecs[k].e_rdy));
            chk($sformatf("v%0d occupancy", k), 64'(occupancy),     64'(vecs[k].e_occ));
        end

        // Randomized traffic against a FIFO model.
        rst = 1'b0; flush = 1'b0; ex_valid = 1'b0; me_ready = 1'b0;
        @(posedge clk); #1;
        q.delete();
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            rst           = 1'b1;
            flush         = ($urandom_range(99) < 5);
            ex_valid      = 1'($urandom_range(1));
            me_ready      = 1'($urandom_range(1));
            ex_alu_o      = 32'(i + 1);
            ex_regs_data2 = $urandom;
            ex_matrix_o   = {$urandom, $urandom, $urandom, $urandom};
            ex_rd         = 5'($urandom);
            ex_rs2        = 5'($urandom);
            ex_ctrl       = 9'($urandom);
            #1;
            chk("rnd ex_ready",  64'(ex_ready),  64'(q.size() < 2));
            chk("rnd me_valid",  64'(me_valid),  64'(q.size() > 0));
            chk("rnd occupancy", 64'(occupancy), 64'(q.size()));
            if (q.size() > 0) begin
                chk("rnd me_alu_o", 64'(me_alu_o),      64'(q[0].alu));
                chk("rnd me_data2", 64'(me_regs_data2), 64'(q[0].d2));
                chk("rnd me_mat",   me_matrix_o[63:0],  q[0].mat[63:0]);
                chk("rnd me_rd",    64'({me_rd, me_rs2}), 64'({q[0].rd, q[0].rs2}));
                chk("rnd me_ctrl",  64'(me_ctrl),       64'(q[0].ctrl));
            end else begin
                chk("rnd bubble ctrl", 64'(me_ctrl), 64'h0);
            end
            acc = ex_valid && (q.size() < 2);
            con = me_ready && (q.size() > 0);
            if (flush) begin
                q.delete();
            end else begin
                if (con) void'(q.pop_front());
                if (acc) begin
                    e.alu = ex_alu_o; e.d2 = ex_regs_data2; e.mat = ex_matrix_o;
                    e.rd = ex_rd; e.rs2 = ex_rs2; e.ctrl = ex_ctrl;
                    q.push_back(e);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
